llr_frame_collector: RTL and testbench

LLR_FRAME_COLLECTOR -- requirements
Module: llr_frame_collector

---
 rtl/llr_frame_collector.sv | 115 +++++++++++
 tb/tb_llr_frame_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/llr_frame_collector.sv
// Collects N = 2**n channel LLRs into a frame register and holds it until the decoder is free.
// Optional macro LLR_SATURATE_EN: store the most-negative LLR as its symmetric counterpart.
module llr_frame_collector #(
    parameter int n = 3,
    parameter int Q = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [Q-1:0]         llr_in,
    input  logic                 llr_valid,
    input  logic                 llr_first,
    output logic                 llr_ready,
    input  logic                 decoder_busy,
    output logic                 data_valid,
    output logic [(2**n)*Q-1:0]  frame_data,
    output logic                 drop_err
);

    localparam int N  = 2**n;
    // Keep the counter at least one bit wide so n=0 (single-LLR frames) still elaborates.
    localparam int CW = (n > 0) ? n : 1;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drop_err_q, drop_err_d;

    logic          accept;
    logic [CW-1:0] slot;
    logic          last_slot;
    logic [Q-1:0]  llr_store;

`ifdef LLR_SATURATE_EN
    localparam logic [Q-1:0] MOST_NEG = {1'b1, {(Q-1){1'b0}}};
    localparam logic [Q-1:0] SAT_VAL  = MOST_NEG | {{(Q-1){1'b0}}, 1'b1};

    always_comb begin
        llr_store = (llr_in == MOST_NEG) ? SAT_VAL : llr_in;
    end
`else
    always_comb begin
        llr_store = llr_in;
    end
`endif

    always_comb begin
        accept     = llr_valid && (state_q == COLLECT);
        slot       = llr_first ? '0 : cnt_q;
        last_slot  = (slot == CW'(N-1));
        state_d    = state_q;
        cnt_d      = cnt_q;
        drop_err_d = drop_err_q;

        if (state_q == COLLECT) begin
            if (accept) begin
                cnt_d = slot + CW'(1);
                if (last_slot) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
        end else begin
            if (llr_valid) begin
                drop_err_d = 1'b1;
            end
            if (!decoder_busy) begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            cnt_q      <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drop_err_q <= drop_err_d;
        end
    end

    // One register per slot; only the addressed slot loads on an accept.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            logic [Q-1:0] slot_q, slot_d;

            always_comb begin
                slot_d = slot_q;
                if (accept && (slot == CW'(gi))) begin
                    slot_d = llr_store;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign frame_data[gi*Q +: Q] = slot_q;
        end
    endgenerate

    assign llr_ready  = (state_q == COLLECT);
    assign data_valid = (state_q == HOLD);
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_llr_frame_collector.sv
// Directed and randomized bench for llr_frame_collector (n=3, Q=6) against a slot-array reference model.
module tb_llr_frame_collector;

    localparam int NB = 3;
    localparam int QB = 6;
    localparam int NF = 8;

    logic              clk;
    logic              rst_n;
    logic [QB-1:0]     llr_in;
    logic              llr_valid;
    logic              llr_first;
    logic              llr_ready;
    logic              decoder_busy;
    logic              data_valid;
    logic [NF*QB-1:0]  frame_data;
    logic              drop_err;

    llr_frame_collector #(.n(NB), .Q(QB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .llr_in      (llr_in),
        .llr_valid   (llr_valid),
        .llr_first   (llr_first),
        .llr_ready   (llr_ready),
        .decoder_busy(decoder_busy),
        .data_valid  (data_valid),
        .frame_data  (frame_data),
        .drop_err    (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the frame as an array of stored values, fill level, hold flag, sticky error.
    logic [QB-1:0] m_slot [NF];
    int            m_fill;
    bit            m_hold;
    bit            m_drop;

    function automatic logic [QB-1:0] stored_value(input logic [QB-1:0] d);
`ifdef LLR_SATURATE_EN
        if ($signed(d) == -32) return 6'(-31);
`endif
        return d;
    endfunction

    function automatic logic [NF*QB-1:0] model_frame();
        logic [NF*QB-1:0] f;
        for (int k = 0; k < NF; k++) f[k*QB +: QB] = m_slot[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NF; k++) m_slot[k] = '0;
        m_fill = 0;
        m_hold = 0;
        m_drop = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".llr_ready"},  64'(llr_ready),  64'(!m_hold));
        chk({tag, ".data_valid"}, 64'(data_valid), 64'(m_hold));
        chk({tag, ".drop_err"},   64'(drop_err),   64'(m_drop));
        chk({tag, ".frame_data"}, 64'(frame_data), 64'(model_frame()));
    endtask

    // Apply one cycle of inputs, advance the model by the same rules, then compare.
    task automatic step(input bit v, input bit f, input logic [QB-1:0] d, input bit b, input string tag);
        int idx;
        llr_valid    = v;
        llr_first    = f;
        llr_in       = d;
        decoder_busy = b;
        @(posedge clk);
        #1;
        if (!m_hold) begin
            if (v) begin
                idx = f ? 0 : m_fill;
                m_slot[idx] = stored_value(d);
                m_fill = idx + 1;
                if (m_fill == NF) begin
                    m_hold = 1;
                    m_fill = 0;
                end
            end
        end else begin
            if (v) m_drop = 1;
            if (!b) m_hold = 0;
        end
        check_all(tag);
        $display("step %s v=%0d f=%0d d=%0d busy=%0d ready=%0d dv=%0d drop=%0d frame=%012h",
                 tag, v, f, d, b, llr_ready, data_valid, drop_err, frame_data);
    endtask

    initial begin
        logic [NF*QB-1:0] exp_frame;
        logic [QB-1:0]    neg_val;

        rst_n        = 1'b0;
        llr_in       = '0;
        llr_valid    = 1'b0;
        llr_first    = 1'b0;
        decoder_busy = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Frame of 0..7, decoder busy: HOLD one cycle after the 8th accept.
        for (int k = 0; k < NF; k++) step(1, k == 0, 6'(k), 1, "ramp");
        for (int k = 0; k < NF; k++) exp_frame[k*QB +: QB] = 6'(k);
        chk("ramp.frame_const", 64'(frame_data), 64'(exp_frame));
        chk("ramp.dv_const", 64'(data_valid), 64'd1);

        // Decoder busy for 20 cycles, frame must stay put; then release.
        for (int c = 0; c < 20; c++) step(0, 0, 6'(c), 1, "busy");
        step(0, 0, 0, 0, "xfer");
        chk("xfer.ready_const", 64'(llr_ready), 64'd1);

        // Restart mid-frame with llr_first.
        for (int k = 0; k < 3; k++) step(1, 0, 6'd5, 1, "pre");
        step(1, 1, 6'd9, 1, "restart");
        for (int k = 0; k < 7; k++) step(1, 0, 6'd1, 1, "post");
        exp_frame = '0;
        exp_frame[5:0] = 6'd9;
        for (int k = 1; k < NF; k++) exp_frame[k*QB +: QB] = 6'd1;
        chk("restart.frame_const", 64'(frame_data), 64'(exp_frame));
        chk("restart.dv_const", 64'(data_valid), 64'd1);

        // LLR offered during HOLD is dropped and flagged.
        step(1, 0, 6'd33, 1, "drop");
        chk("drop.flag_const", 64'(drop_err), 64'd1);
        step(0, 0, 0, 0, "xfer2");
        for (int k = 0; k < NF; k++) step(1, k == 0, 6'(k + 20), 0, "sticky");
        step(0, 0, 0, 0, "xfer3");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 6'($urandom), $urandom_range(0, 1) == 1, "rand");
        end

        // Return to COLLECT, then asynchronous reset mid-frame between clock edges.
        step(0, 0, 0, 0, "drain");
        step(0, 0, 0, 0, "drain");
        for (int k = 0; k < 5; k++) step(1, k == 0, 6'(k + 40), 1, "partial");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        rst_n = 1'b1;
        step(1, 0, 6'd17, 1, "after_rst");
        chk("after_rst.slot0", 64'(frame_data[5:0]), 64'd17);

        // Most-negative LLR handling.
        for (int k = 1; k < NF; k++) step(1, 0, 6'(k), 0, "fill");
        step(0, 0, 0, 0, "xfer4");
        step(1, 1, 6'b100000, 1, "neg");
`ifdef LLR_SATURATE_EN
        neg_val = 6'b100001;
`else
        neg_val = 6'b100000;
`endif
        chk("neg.slot0", 64'(frame_data[5:0]), 64'(neg_val));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
